// File: rtl/aes_out_serializer.sv
// Serializes 128-bit AES core results into a ready/valid byte stream.
// Define AES_OUT_SKID_EN to add a one-block skid buffer behind the primary buffer.
module aes_out_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] core_state_out,
  input  logic         core_done,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         overflow,
  input  logic         clr_overflow
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]   state_r, state_s;
  logic [3:0]   cnt_r, cnt_s;
  logic [127:0] buf_r, buf_s;
  logic         ovf_r, ovf_s;
  logic         drop_s;
  logic         xfer_s;
  logic         last_xfer_s;
  logic         send_s;
  logic [7:0]   out_byte_r;
  logic         out_valid_r;
  logic         out_last_r;
  logic         busy_r;
  logic         skid_busy_s;

`ifdef AES_OUT_SKID_EN
  logic [127:0] skid_r, skid_s;
  logic         skid_full_r, skid_full_s;
`endif

  // Byte k of a block in transmit order.
  function automatic logic [7:0] byte_sel(input logic [127:0] blk, input logic [3:0] k);
    logic [6:0] base;
    if (MSB_FIRST) begin
      base = {4'd15 - k, 3'd0};
    end else begin
      base = {k, 3'd0};
    end
    return blk[base +: 8];
  endfunction

  // Next-state decode for state, counter, buffers and overflow.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    buf_s       = buf_r;
    drop_s      = 1'b0;
`ifdef AES_OUT_SKID_EN
    skid_s      = skid_r;
    skid_full_s = skid_full_r;
`endif
    xfer_s      = (state_r == S_SEND) && out_ready;
    last_xfer_s = xfer_s && (cnt_r == 4'd15);
    case (state_r)
      S_IDLE: begin
        if (core_done) begin
          buf_s   = core_state_out;
          cnt_s   = 4'd0;
          state_s = S_SEND;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SEND: begin
        if (xfer_s) begin
          cnt_s = cnt_r + 4'd1;
        end else begin
          cnt_s = cnt_r;
        end
        if (last_xfer_s) begin
`ifdef AES_OUT_SKID_EN
          // The held block goes first; a coinciding new block refills the skid.
          if (skid_full_r) begin
            buf_s = skid_r;
            cnt_s = 4'd0;
            if (core_done) begin
              skid_s = core_state_out;
            end else begin
              skid_full_s = 1'b0;
            end
          end else if (core_done) begin
            buf_s = core_state_out;
            cnt_s = 4'd0;
          end else begin
            state_s = S_IDLE;
          end
`else
          if (core_done) begin
            buf_s = core_state_out;
            cnt_s = 4'd0;
          end else begin
            state_s = S_IDLE;
          end
`endif
        end else if (core_done) begin
`ifdef AES_OUT_SKID_EN
          if (!skid_full_r) begin
            skid_s      = core_state_out;
            skid_full_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
`else
          drop_s = 1'b1;
`endif
        end else begin
          drop_s = 1'b0;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop_s) begin
      ovf_s = 1'b1;
    end else if (clr_overflow) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end

    send_s = (state_s == S_SEND);
`ifdef AES_OUT_SKID_EN
    skid_busy_s = skid_full_s;
`else
    skid_busy_s = 1'b0;
`endif
  end

  // Core state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      buf_r   <= 128'd0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      buf_r   <= buf_s;
      ovf_r   <= ovf_s;
    end
  end

`ifdef AES_OUT_SKID_EN
  // Skid buffer and its occupied flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_r      <= 128'd0;
      skid_full_r <= 1'b0;
    end else begin
      skid_r      <= skid_s;
      skid_full_r <= skid_full_s;
    end
  end
`endif

  // Output registers, loaded from the next-state values so they track state with no lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_byte_r  <= 8'h00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_byte_r  <= send_s ? byte_sel(buf_s, cnt_s) : 8'h00;
      out_valid_r <= send_s;
      out_last_r  <= send_s && (cnt_s == 4'd15);
      busy_r      <= send_s || skid_busy_s;
    end
  end

  assign out_byte  = out_byte_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench for aes_out_serializer: directed table, corner sequences, random vs queue model.
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] core_state_out;
  logic         core_done;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         overflow;
  logic         clr_overflow;

  localparam logic [127:0] BLK_A = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] BLK_B = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_C = 128'hdeadbeef0123456789abcdeffedcba98;
`ifdef AES_OUT_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  aes_out_serializer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_state_out (core_state_out),
    .core_done      (core_done),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: queue of bytes still owed to the sink; capacity counted in whole blocks.
  logic [7:0] exp_q[$];
  logic       ovf_m;

  typedef struct {
    logic       d;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_byte;
    logic       e_last;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int blocks_held();
    return (exp_q.size() + 15) / 16;
  endfunction

  task automatic push_block(input logic [127:0] b);
    for (int i = 0; i < 16; i++) exp_q.push_back(b[127 - 8*i -: 8]);
  endtask

  task automatic check_model();
    logic       v;
    logic [7:0] eb;
    v  = (exp_q.size() > 0);
    eb = v ? exp_q[0] : 8'h00;
    chk("out_valid", out_valid, v);
    chk("out_byte", out_byte, eb);
    chk("out_last", out_last, v && (exp_q.size() % 16 == 1));
    chk("busy", busy, v);
    chk("overflow", overflow, ovf_m);
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it.
  task automatic step(input logic d, input logic [127:0] data, input logic rdy, input logic clr);
    logic drop;
    core_done      = d;
    core_state_out = data;
    out_ready      = rdy;
    clr_overflow   = clr;
    @(posedge clk);
    drop = 1'b0;
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    if (d) begin
      if (blocks_held() < CAP) push_block(data);
      else drop = 1'b1;
    end
    if (drop) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    #1;
    check_model();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, 128'd0, 1'b1, 1'b0);
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h8e, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h8e, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'ha2, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 8'hb7, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'hb7, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 8'hca, 1'b0};

    rst_n = 1'b0; core_done = 1'b0; core_state_out = 128'd0;
    out_ready = 1'b0; clr_overflow = 1'b0; ovf_m = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_byte", out_byte, 8'h00);
    chk("rst_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_model();

    // Directed table with backpressure; block A then drained at full rate.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].d, BLK_A, tbl[i].rdy, 1'b0);
      chk("tbl_valid", out_valid, tbl[i].e_valid);
      chk("tbl_byte", out_byte, tbl[i].e_byte);
      chk("tbl_last", out_last, tbl[i].e_last);
    end
    drain();

    // Back-to-back: new block on the last-byte transfer.
    step(1'b1, BLK_A, 1'b1, 1'b0);
    for (int i = 0; i < 20 && exp_q.size() > 1; i++) step(1'b0, 128'd0, 1'b1, 1'b0);
    chk("b2b_last_byte", out_byte, 8'h89);
    chk("b2b_last_flag", out_last, 1'b1);
    step(1'b1, BLK_B, 1'b1, 1'b0);
    chk("b2b_first_byte", out_byte, 8'h00);
    chk("b2b_no_gap", out_valid, 1'b1);
    chk("b2b_ovf", overflow, 1'b0);
    drain();

    // Pulse at counter 5: dropped without skid, held in skid otherwise.
    step(1'b1, BLK_A, 1'b1, 1'b0);
    repeat (4) step(1'b0, 128'd0, 1'b1, 1'b0);
    step(1'b0, 128'd0, 1'b1, 1'b0);
    step(1'b1, BLK_B, 1'b0, 1'b0);
    chk("c5_byte", out_byte, 8'h67);
`ifndef AES_OUT_SKID_EN
    chk("drop_ovf", overflow, 1'b1);
`endif
    step(1'b0, 128'd0, 1'b1, 1'b1);
    chk("clr_ovf", overflow, 1'b0);
    drain();

    // Clear and drop in the same cycle: drop wins.
    step(1'b1, BLK_A, 1'b0, 1'b0);
    step(1'b1, BLK_B, 1'b0, 1'b0);
    step(1'b1, BLK_C, 1'b0, 1'b1);
    chk("drop_beats_clr", overflow, 1'b1);

    // Reset mid-block at counter 7 with overflow pending.
    repeat (7) step(1'b0, 128'd0, 1'b1, 1'b0);
    chk("pre_rst_byte", out_byte, 8'hbf);
    chk("pre_rst_ovf", overflow, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_byte", out_byte, 8'h00);
    exp_q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_model();
    step(1'b0, 128'd0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
